noc_rx_arbiter: RTL and testbench
=================================

Name: noc_rx_arbiter

Overview:
- NoC-side receiver for the per-CPU valid/ready data streams driven by each cpu_dpi_server instance.
- Accepts 64-bit words from CPU_NB CPUs and buffers them in one FIFO per CPU.
- Merges the buffered words onto a single output stream using round-robin arbitration.
- Tags each output word with its source CPU index, for the NoC routing logic downstream.

Parameters:
- CPU_NB, 4: number of CPU streams, ≥2.
- FIFO_DEPTH, 4: per-CPU FIFO entries; power of 2, ≥2.
- IDX_W, $clog2(CPU_NB): width of out_cpu_idx (derived).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- data_vld  input  [CPU_NB] x 1  per-CPU word valid.
- data_rdy  output  [CPU_NB] x 1  per-CPU ready.
- data  input  [CPU_NB] x 64  per-CPU word.
- out_vld  output  1  merged stream valid.
- out_rdy  input  1  merged stream ready from the NoC.
- out_data  output  64  merged word.
- out_cpu_idx  output  IDX_W  source CPU of out_data.
- stat_cnt  output  [CPU_NB] x 32  per-CPU accepted-word count; see Optional Feature.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - all FIFO counts and pointers = 0
  - out_vld = 0, out_data = 0, out_cpu_idx = 0
  - RR pointer (last granted) = CPU_NB-1, so CPU 0 has first priority
  - stat_cnt = 0
- data_rdy[i]:
  - = (count[i] != FIFO_DEPTH) && !rst
  - Depends only on registered state, never on data_vld.
  - Reads 0 during every cycle rst is high.
- Input transfer: when data_vld[i] && data_rdy[i] at a rising edge, data[i] is written at FIFO i tail.
  - A CPU may hold data_vld with data_rdy low indefinitely; no word is lost or duplicated.
- Output register:
  - Loads when (!out_vld || out_rdy) && any FIFO is non-empty.
  - If out_vld && out_rdy and no FIFO is non-empty, out_vld drops to 0 next cycle.
  - While out_vld && !out_rdy, out_data and out_cpu_idx hold stable.
- Arbitration (round-robin):
  - Search begins at index (RR pointer + 1) mod CPU_NB over non-empty FIFOs.
  - The first hit is popped into the output register, and the RR pointer is set to that index.
  - The RR pointer changes only on a load.
- Latency: a word accepted at edge N can present on out_vld at the earliest after edge N+1 (1 empty-FIFO write cycle, then load).
- Simultaneous push and pop on the same FIFO: count unchanged, and the pointers advance independently.
- Full FIFO: data_rdy is low, so a pop in that cycle does not enable a push in the same cycle; the push happens the next cycle.
- Ordering:
  - Per-CPU order is preserved.
  - No ordering between different CPUs is guaranteed beyond the round-robin rule.
- Reset asserted mid-operation flushes all FIFOs and the output register; in-flight words are discarded.
- Pointer arithmetic wraps mod FIFO_DEPTH; count range is 0..FIFO_DEPTH.

Optional Feature:
- Macro: NOC_RX_STATS_EN.
- When defined:
  - stat_cnt[i] increments by 1 on every accepted input transfer of CPU i.
  - 32-bit counter, wraps from 0xFFFF_FFFF to 0.
  - Cleared by rst.
- When not defined: stat_cnt is tied to 0 and no counter flops are built.

Test Plan (CPU_NB=4, FIFO_DEPTH=4):
1. Reset: rst high for 3 cycles while data_vld[0]=1 -> data_rdy all 0 and out_vld=0. On the first cycle after rst drops, data_rdy = 1 on all CPUs.
2. Single word: CPU 2 sends 0xDEAD_BEEF_0000_0002, accepted at edge N, out_rdy=1 -> after edge N+1, out_vld=1 with out_data=0xDEAD_BEEF_0000_0002 and out_cpu_idx=2. After edge N+2, out_vld=0.
3. Fairness: all 4 CPUs continuously valid, each sending its own incrementing data; out_rdy=1 -> out_cpu_idx sequence is 0,1,2,3,0,1,... and each CPU's data is in order.
4. Backpressure: out_rdy=0, CPU 1 streams words 1..6.
   - Required: words 1..5 accepted (1 in the output register, 4 in the FIFO), then data_rdy[1]=0 with word 6 held.
   - Then raise out_rdy=1: output is 1,2,3,4,5,6 in order, with no duplicates.
5. Reset mid-stream: 3 words queued in CPU 3 with out_rdy=0, then 1 rst cycle -> out_vld=0 and no queued word ever appears. A subsequent word 0x55 from CPU 3 is output alone.
6. NOC_RX_STATS_EN defined: CPU 0 sends 10 words and CPU 3 sends 7 -> stat_cnt[0]=10, stat_cnt[3]=7, others 0. After rst, all are 0.

Source files
------------

// File: rtl/noc_rx_arbiter_if.sv
// Handshake bundle between the per-CPU input streams, the merged NoC output and the stats tap.
// The slave modport is the arbiter's view; the master modport is the CPU/NoC side.
interface noc_rx_arbiter_if #(
  parameter int unsigned CPU_NB = 4
);
  localparam int unsigned IDX_W = $clog2(CPU_NB);

  logic [CPU_NB-1:0]        data_vld;
  logic [CPU_NB-1:0]        data_rdy;
  logic [CPU_NB-1:0][63:0]  data;
  logic                     out_vld;
  logic                     out_rdy;
  logic [63:0]              out_data;
  logic [IDX_W-1:0]         out_cpu_idx;
  logic [CPU_NB-1:0][31:0]  stat_cnt;

  modport master (
    output data_vld, data, out_rdy,
    input  data_rdy, out_vld, out_data, out_cpu_idx, stat_cnt
  );

  modport slave (
    input  data_vld, data, out_rdy,
    output data_rdy, out_vld, out_data, out_cpu_idx, stat_cnt
  );
endinterface

// File: rtl/noc_rx_arbiter.sv
// Per-CPU FIFOs merged round-robin onto one tagged output stream.
// Optional per-CPU accepted-word counters are built when NOC_RX_STATS_EN is defined.
module noc_rx_arbiter #(
  parameter int unsigned CPU_NB     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  noc_rx_arbiter_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(CPU_NB);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [63:0]      mem_q    [CPU_NB][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [CPU_NB];
  logic [PTR_W-1:0] rd_ptr_q [CPU_NB];
  logic [CNT_W-1:0] count_q  [CPU_NB];

  logic [CPU_NB-1:0] nonempty;
  logic [CPU_NB-1:0] data_rdy;
  logic [CPU_NB-1:0] push;
  logic [CPU_NB-1:0] pop;

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             load;

  logic             out_vld_q;
  logic [63:0]      out_data_q;
  logic [IDX_W-1:0] out_idx_q;

  // Ready is a function of registered occupancy only, forced low during reset.
  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      nonempty[i] = (count_q[i] != '0);
      data_rdy[i] = (count_q[i] != CNT_W'(FIFO_DEPTH)) && !rst;
      push[i]     = bus.data_vld[i] && data_rdy[i];
    end
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= CPU_NB; k++) begin
      cand = (32'(rr_q) + k) % CPU_NB;
      if (!grant_found && nonempty[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
    load = (!out_vld_q || bus.out_rdy) && grant_found;
    for (int i = 0; i < CPU_NB; i++) begin
      pop[i] = load && (grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= bus.data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CPU_NB; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q       <= IDX_W'(CPU_NB - 1);
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      for (int i = 0; i < CPU_NB; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (load) begin
        out_vld_q  <= 1'b1;
        out_data_q <= mem_q[grant_idx][rd_ptr_q[grant_idx]];
        out_idx_q  <= grant_idx;
        rr_q       <= grant_idx;
      end else if (bus.out_rdy) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign bus.data_rdy    = data_rdy;
  assign bus.out_vld     = out_vld_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_cpu_idx = out_idx_q;

`ifdef NOC_RX_STATS_EN
  logic [31:0] stat_q [CPU_NB];

  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (rst) begin
        stat_q[i] <= '0;
      end else if (push[i]) begin
        stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      bus.stat_cnt[i] = stat_q[i];
    end
  end
`else
  assign bus.stat_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_rx_arbiter.sv
// Randomised bench for noc_rx_arbiter: queue-based reference model feeds an expected-output
// scoreboard that a separate monitor drains on every output handshake.
module tb_noc_rx_arbiter;

  localparam int unsigned CPU_NB = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IDX_W  = $clog2(CPU_NB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_rx_arbiter_if #(.CPU_NB(CPU_NB)) bus ();

  noc_rx_arbiter #(.CPU_NB(CPU_NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is a queue, the output register is a valid/word/index triple.
  logic [63:0]       mq [CPU_NB][$];
  logic              m_vld  = 1'b0;
  logic [63:0]       m_data = '0;
  int                m_idx  = 0;
  int                m_rr   = CPU_NB - 1;
  logic [31:0]       m_stat [CPU_NB];
  logic [CPU_NB-1:0] acc    = '0;
  logic [IDX_W+63:0] exp_q  [$];

  // Source side: words each CPU still has to send.
  logic [63:0] src_q [CPU_NB][$];
  int          vld_pct  = 100;
  int          rdy_mode = 1;  // 0: hold off, 1: always ready, 2: random

  always @(posedge clk) begin
    int g;
    g = -1;
    acc = '0;
    if (rst) begin
      for (int i = 0; i < CPU_NB; i++) begin
        mq[i].delete();
        m_stat[i] = '0;
      end
      m_vld  = 1'b0;
      m_data = '0;
      m_idx  = 0;
      m_rr   = CPU_NB - 1;
      exp_q.delete();
    end else begin
      for (int i = 0; i < CPU_NB; i++) begin
        acc[i] = bus.data_vld[i] && (mq[i].size() != DEPTH);
      end
      for (int k = 1; k <= CPU_NB; k++) begin
        int c;
        c = (m_rr + k) % CPU_NB;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g >= 0 && (!m_vld || bus.out_rdy)) begin
        m_data = mq[g].pop_front();
        m_idx  = g;
        m_vld  = 1'b1;
        m_rr   = g;
        exp_q.push_back({IDX_W'(g), m_data});
      end else if (bus.out_rdy) begin
        m_vld = 1'b0;
      end
      for (int i = 0; i < CPU_NB; i++) begin
        if (acc[i]) begin
          mq[i].push_back(bus.data[i]);
          m_stat[i] = m_stat[i] + 32'd1;
        end
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge.
  initial begin
    bus.data_vld = '0;
    bus.data     = '0;
    bus.out_rdy  = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < CPU_NB; i++) begin
      if (acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
      if (src_q[i].size() == 0) begin
        bus.data_vld[i] = 1'b0;
        bus.data[i]     = '0;
      end else begin
        if (acc[i] || !bus.data_vld[i]) bus.data_vld[i] = ($urandom_range(99) < vld_pct);
        bus.data[i] = src_q[i][0];
      end
    end
    bus.out_rdy = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
  end

  // Monitor: compares on the falling edge, pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    logic [IDX_W+63:0] e;
    for (int i = 0; i < CPU_NB; i++) begin
      check($sformatf("data_rdy[%0d]", i), 64'(bus.data_rdy[i]),
            64'(!rst && mq[i].size() != DEPTH));
`ifdef NOC_RX_STATS_EN
      check($sformatf("stat_cnt[%0d]", i), 64'(bus.stat_cnt[i]), 64'(m_stat[i]));
`else
      check($sformatf("stat_cnt[%0d]", i), 64'(bus.stat_cnt[i]), 64'd0);
`endif
    end
    check("out_vld", 64'(bus.out_vld), 64'(m_vld));
    if (m_vld) begin
      check("out_data", bus.out_data, m_data);
      check("out_cpu_idx", 64'(bus.out_cpu_idx), 64'(m_idx));
    end
    if (!rst && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got idx %0d data %h, required no output",
                 bus.out_cpu_idx, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", bus.out_data, e[63:0]);
        check("sb_idx", 64'(bus.out_cpu_idx), 64'(e[IDX_W+63:64]));
      end
    end
  end

  function automatic bit idle();
    idle = !m_vld;
    for (int i = 0; i < CPU_NB; i++) begin
      if (src_q[i].size() != 0 || mq[i].size() != 0) idle = 1'b0;
    end
  endfunction

  task automatic drain(input string name);
    int t;
    t = 0;
    while (!idle() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles, required idle", name, t);
    end
  endtask

  task automatic pulse_rst(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < CPU_NB; i++) m_stat[i] = '0;

    // Reset with CPU 0 already presenting a word.
    src_q[0].push_back(64'h0000_0000_0000_1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_rdy", 64'(bus.data_rdy), 64'd0);
    check("rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_idx", 64'(bus.out_cpu_idx), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_data_rdy", 64'(bus.data_rdy), 64'hf);
    drain("t1_drain");

    // Single word from CPU 2.
    @(negedge clk);
    src_q[2].push_back(64'hDEAD_BEEF_0000_0002);
    drain("t2_drain");

    // Fairness: every CPU streaming continuously.
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < CPU_NB; i++) src_q[i].push_back((64'(i) << 32) | 64'(s));
    end
    drain("t3_drain");

    // Backpressure: CPU 1 fills output register plus FIFO, sixth word held.
    @(negedge clk);
    rdy_mode = 0;
    for (int w = 1; w <= 6; w++) src_q[1].push_back(64'(w));
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_data_rdy1", 64'(bus.data_rdy[1]), 64'd0);
    check("bp_out_vld", 64'(bus.out_vld), 64'd1);
    check("bp_out_data", bus.out_data, 64'd1);
    rdy_mode = 1;
    drain("t4_drain");

    // Reset mid-stream discards queued CPU 3 words.
    @(negedge clk);
    rdy_mode = 0;
    for (int w = 1; w <= 3; w++) src_q[3].push_back(64'h300 + 64'(w));
    repeat (8) @(posedge clk);
    pulse_rst(1);
    @(negedge clk);
    check("mid_rst_out_vld", 64'(bus.out_vld), 64'd0);
    src_q[3].push_back(64'h55);
    rdy_mode = 1;
    drain("t5_drain");

    // Accepted-word counters.
    pulse_rst(1);
    @(negedge clk);
    for (int w = 0; w < 10; w++) src_q[0].push_back(64'hA000 + 64'(w));
    for (int w = 0; w < 7; w++)  src_q[3].push_back(64'hB000 + 64'(w));
    drain("t6_drain");
    @(negedge clk);
`ifdef NOC_RX_STATS_EN
    check("stat0_total", 64'(bus.stat_cnt[0]), 64'd10);
    check("stat3_total", 64'(bus.stat_cnt[3]), 64'd7);
`else
    check("stat0_total", 64'(bus.stat_cnt[0]), 64'd0);
    check("stat3_total", 64'(bus.stat_cnt[3]), 64'd0);
`endif
    check("stat1_total", 64'(bus.stat_cnt[1]), 64'd0);
    check("stat2_total", 64'(bus.stat_cnt[2]), 64'd0);
    pulse_rst(1);
    @(negedge clk);
    for (int i = 0; i < CPU_NB; i++) check($sformatf("stat_clr[%0d]", i), 64'(bus.stat_cnt[i]), 64'd0);

    // Random traffic with random backpressure.
    for (int r = 0; r < 4; r++) begin
      int t;
      @(negedge clk);
      vld_pct  = 30 + $urandom_range(70);
      rdy_mode = 2;
      for (int i = 0; i < CPU_NB; i++) begin
        int n;
        n = $urandom_range(40, 10);
        for (int w = 0; w < n; w++) src_q[i].push_back({$urandom, $urandom});
      end
      t = 0;
      while (t < 2000 && (src_q[0].size() + src_q[1].size() + src_q[2].size()
                          + src_q[3].size()) != 0) begin
        @(posedge clk);
        t++;
      end
      @(negedge clk);
      rdy_mode = 1;
      vld_pct  = 100;
      drain($sformatf("rand%0d_drain", r));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
